// File: rtl/lock_pkg.sv
`timescale 1ns/1ps
// lock_pkg: shared FSM states, key codes and seven-segment patterns for the keypad lock
package lock_pkg;
  typedef enum logic [1:0] {LOCKED, OPEN, CHANGE_PW} lock_state_t;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  // Active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_O     = 8'hA3;
  localparam logic [7:0] SEG_C     = 8'hC6;
  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0: seg_digit = 8'hC0;
      4'd1: seg_digit = 8'hF9;
      4'd2: seg_digit = 8'hA4;
      4'd3: seg_digit = 8'hB0;
      4'd4: seg_digit = 8'h99;
      4'd5: seg_digit = 8'h92;
      4'd6: seg_digit = 8'h82;
      4'd7: seg_digit = 8'hF8;
      4'd8: seg_digit = 8'h80;
      4'd9: seg_digit = 8'h90;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/keypad_scan.sv
`timescale 1ns/1ps
// keypad_scan: column scan, row synchronise/debounce and key decode for a 4x3 matrix
module keypad_scan
  import lock_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic       key_valid,
  output logic [3:0] key_code
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  logic [3:0] row_m, row_s, row_p;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] db_cnt;
  logic armed, idle, stable;
  logic [1:0] r, c;
  logic [3:0] code;
  assign idle   = row_s == 4'hF;
  assign stable = (row_s == row_p) && (db_cnt == DB_LAST);
  assign r = !row_s[0] ? 2'd0 : !row_s[1] ? 2'd1 : !row_s[2] ? 2'd2 : 2'd3;
  assign c = !col[0] ? 2'd0 : !col[1] ? 2'd1 : 2'd2;
  assign code = (r != 2'd3) ? {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1 :
                (c == 2'd0) ? KEY_STAR : (c == 2'd1) ? 4'd0 : KEY_HASH;
  // Two-stage row synchroniser plus a delayed copy for change detection
  always_ff @(posedge clock or negedge reset)
    if (!reset) {row_m, row_s, row_p} <= 12'hFFF;
    else {row_m, row_s, row_p} <= {row, row_m, row_s};
  // Rotate the active column while no row is pulled low; freeze on a press
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      scan_cnt <= '0;
      col      <= 3'b110;
    end else if (idle) begin
      scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
      col      <= (scan_cnt == SCAN_LAST) ? {col[1:0], col[2]} : col;
    end
  // Stability counter restarts on every row change and saturates once settled
  always_ff @(posedge clock or negedge reset)
    if (!reset) db_cnt <= '0;
    else db_cnt <= (row_s != row_p) ? '0 : (db_cnt == DB_LAST) ? db_cnt : db_cnt + 1'b1;
  // A settled release re-arms; the next settled press fires one pulse
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      armed     <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      armed     <= stable ? idle : armed;
      key_valid <= stable && !idle && armed;
      key_code  <= (stable && !idle && armed) ? code : key_code;
    end
endmodule

// File: rtl/keypad_lock_top.sv
`timescale 1ns/1ps
// keypad_lock_top: keypad combination lock with LEDs and 8-digit display; define MASK_DIGITS_EN to show entered digits as '-'
module keypad_lock_top
  import lock_pkg::*;
#(
  parameter int          SCAN_DIV        = 16,
  parameter int          DEBOUNCE_CYCLES = 500,
  parameter int          REFRESH_DIV     = 1000,
  parameter logic [15:0] DEFAULT_PW      = 16'h1234
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_1,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic       OPEN_1,
  output logic       SAVE_LIGHT_1,
  output logic       LOCK_1,
  output logic       CHANGE,
  output logic       SET,
  output logic [7:0] duan,
  output logic [7:0] wei
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  lock_state_t state_q, state_n;
  logic [15:0] buf_q, buf_n, pw_q, pw_n;
  logic [2:0] cnt_q, cnt_n, dig_q;
  logic save_n, set_m, set_p, set_fall;
  logic key_valid, digit, star, hash, full;
  logic [3:0] key_code;
  logic [RW-1:0] ref_cnt;
  logic [7:0] digit_seg, seg_n;
  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_scan (
    .clock(clock), .reset(reset), .row(row), .col(col),
    .key_valid(key_valid), .key_code(key_code)
  );
  assign digit    = key_valid && (key_code < 4'd10);
  assign star     = key_valid && (key_code == KEY_STAR);
  assign hash     = key_valid && (key_code == KEY_HASH);
  assign full     = cnt_q == 3'd4;
  assign set_fall = set_p && !SET;
  // Synchronise the password-change switch; the extra stage detects its falling edge
  always_ff @(posedge clock or negedge reset)
    if (!reset) {set_m, SET, set_p} <= 3'b000;
    else {set_m, SET, set_p} <= {set_1, set_m, SET};
  // Lock FSM next state: digit entry, code check and password update
  always_comb begin
    state_n = state_q;
    buf_n   = buf_q;
    cnt_n   = cnt_q;
    pw_n    = pw_q;
    save_n  = SAVE_LIGHT_1;
    if (digit && !full) begin
      buf_n = {buf_q[11:0], key_code};
      cnt_n = cnt_q + 3'd1;
    end
    case (state_q)
      LOCKED:
        if (hash && full && buf_q == pw_q) state_n = OPEN;
        else if (star || hash) begin
          buf_n = '0;
          cnt_n = '0;
        end
      OPEN:
        if (star) begin
          state_n = LOCKED;
          buf_n   = '0;
          cnt_n   = '0;
          save_n  = 1'b0;
        end else if (hash && SET) begin
          state_n = CHANGE_PW;
          buf_n   = '0;
          cnt_n   = '0;
        end
      CHANGE_PW:
        if (set_fall || star) state_n = OPEN;
        else if (hash && full) begin
          pw_n    = buf_q;
          save_n  = 1'b1;
          state_n = OPEN;
        end
      default: state_n = LOCKED;
    endcase
  end
  // Lock state, entry buffer, password and registered indicators
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q      <= LOCKED;
      buf_q        <= '0;
      cnt_q        <= '0;
      pw_q         <= DEFAULT_PW;
      SAVE_LIGHT_1 <= 1'b0;
      LOCK_1       <= 1'b1;
      OPEN_1       <= 1'b0;
      CHANGE       <= 1'b0;
    end else begin
      state_q      <= state_n;
      buf_q        <= buf_n;
      cnt_q        <= cnt_n;
      pw_q         <= pw_n;
      SAVE_LIGHT_1 <= save_n;
      LOCK_1       <= state_q == LOCKED;
      OPEN_1       <= state_q == OPEN;
      CHANGE       <= state_q == CHANGE_PW;
    end
`ifdef MASK_DIGITS_EN
  assign digit_seg = SEG_DASH;
`else
  assign digit_seg = seg_digit(buf_q[{dig_q[1:0], 2'b00} +: 4]);
`endif
  assign seg_n = (dig_q == 3'd7) ? ((state_q == LOCKED) ? SEG_L : (state_q == OPEN) ? SEG_O : SEG_C) :
                 dig_q[2] ? SEG_BLANK : (dig_q < cnt_q) ? digit_seg : SEG_BLANK;
  // Step the active digit every REFRESH_DIV cycles and drive the multiplexed display
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ref_cnt <= '0;
      dig_q   <= '0;
      wei     <= 8'hFF;
      duan    <= 8'hFF;
    end else begin
      ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + 1'b1;
      dig_q   <= (ref_cnt == REF_LAST) ? dig_q + 3'd1 : dig_q;
      wei     <= ~(8'b1 << dig_q);
      duan    <= seg_n;
    end
endmodule

// File: tb/tb_keypad_lock_top.sv
`timescale 1ns/1ps
// tb_keypad_lock_top: directed self-checking bench for the keypad lock top level
module tb_keypad_lock_top;
  logic clock = 1'b0, reset = 1'b0, set_1 = 1'b0;
  logic [3:0] row;
  logic [2:0] col;
  logic OPEN_1, SAVE_LIGHT_1, LOCK_1, CHANGE, SET;
  logic [7:0] duan, wei;
  logic pressed = 1'b0;
  logic [1:0] kr = 2'd0, kc = 2'd0;
  int checks = 0, fails = 0, key_cnt = 0;
  logic [3:0] last_code = 4'd0;
  logic [7:0] disp [8];
  localparam logic [7:0] B = 8'hFF;
  localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #10 clock = ~clock;

  // Column-aware keypad: the pressed row reads low only while its column is driven
  assign row = (pressed && col[kc] == 1'b0) ? ~(4'b0001 << kr) : 4'hF;

  keypad_lock_top #(.REFRESH_DIV(8)) dut (
    .clock(clock), .reset(reset), .set_1(set_1), .row(row), .col(col),
    .OPEN_1(OPEN_1), .SAVE_LIGHT_1(SAVE_LIGHT_1), .LOCK_1(LOCK_1), .CHANGE(CHANGE),
    .SET(SET), .duan(duan), .wei(wei)
  );

  always @(posedge clock)
    if (dut.u_scan.key_valid) begin
      key_cnt   <= key_cnt + 1;
      last_code <= dut.u_scan.key_code;
    end

  task automatic press(input int k, input int bounce);
    kr = (k >= 1 && k <= 9) ? 2'((k - 1) / 3) : 2'd3;
    kc = (k >= 1 && k <= 9) ? 2'((k - 1) % 3) : (k == 0) ? 2'd1 : (k == 10) ? 2'd0 : 2'd2;
    repeat (bounce) begin pressed = ~pressed; #($urandom_range(0, 1022)); end
    pressed = 1'b1;
    if (bounce > 0) #21000; else #12500;
    repeat (bounce) begin pressed = ~pressed; #($urandom_range(0, 1022)); end
    pressed = 1'b0;
    #11500;
  endtask

  task automatic read_disp();
    logic [7:0] w;
    for (int i = 0; i < 8; i++) disp[i] = 8'h00;
    repeat (80) begin
      @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        w = ~(8'b1 << i);
        if (wei == w) disp[i] = duan;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    #200;
    checks++; if (col !== 3'b110) begin fails++; $display("FAIL reset_col: got %b want 110", col); end
    checks++; if (LOCK_1 !== 1'b1) begin fails++; $display("FAIL reset_lock: got %b want 1", LOCK_1); end
    checks++; if (OPEN_1 !== 1'b0) begin fails++; $display("FAIL reset_open: got %b want 0", OPEN_1); end
    checks++; if (SAVE_LIGHT_1 !== 1'b0) begin fails++; $display("FAIL reset_save: got %b want 0", SAVE_LIGHT_1); end
    checks++; if (CHANGE !== 1'b0 || SET !== 1'b0) begin fails++; $display("FAIL reset_change_set: got %b%b want 00", CHANGE, SET); end
    checks++; if (wei !== 8'hFF || duan !== 8'hFF) begin fails++; $display("FAIL reset_display: got wei=%h duan=%h want FF FF", wei, duan); end
    reset = 1'b1;
    n = 0;
    while (col !== 3'b101 && n < 40) begin @(negedge clock); n++; end
    checks++; if (col !== 3'b101) begin fails++; $display("FAIL scan_rotate: got %b want 101", col); end
    n = 0;
    while (col !== 3'b011 && n < 40) begin @(negedge clock); n++; end
    checks++; if (col !== 3'b011) begin fails++; $display("FAIL scan_rotate2: got %b want 011", col); end
    read_disp();
    for (int i = 0; i < 7; i++) begin
      checks++; if (disp[i] !== B) begin fails++; $display("FAIL reset_digit%0d: got %h want FF", i, disp[i]); end
    end
    checks++; if (disp[7] !== 8'hC7) begin fails++; $display("FAIL reset_state_digit: got %h want C7", disp[7]); end
    #11000;
  endtask

  task automatic test_wrong_code();
    int k0;
    logic [7:0] exp [4];
    k0 = key_cnt;
    press(1, 0); press(2, 0); press(3, 0); press(5, 0);
    checks++; if (key_cnt - k0 !== 4) begin fails++; $display("FAIL wrong_keycount: got %0d want 4", key_cnt - k0); end
    read_disp();
    exp = '{SEG[5], SEG[3], SEG[2], SEG[1]};
    for (int i = 0; i < 4; i++) begin
      checks++; if (disp[i] !== exp[i]) begin fails++; $display("FAIL wrong_buf_digit%0d: got %h want %h", i, disp[i], exp[i]); end
    end
    press(11, 0);
    checks++; if (LOCK_1 !== 1'b1 || OPEN_1 !== 1'b0) begin fails++; $display("FAIL wrong_1235_state: got lock=%b open=%b want 1 0", LOCK_1, OPEN_1); end
    read_disp();
    for (int i = 0; i < 4; i++) begin
      checks++; if (disp[i] !== B) begin fails++; $display("FAIL wrong_cleared_digit%0d: got %h want FF", i, disp[i]); end
    end
    press(1, 0); press(2, 0); press(3, 0); press(11, 0);
    checks++; if (LOCK_1 !== 1'b1 || OPEN_1 !== 1'b0) begin fails++; $display("FAIL short_code_state: got lock=%b open=%b want 1 0", LOCK_1, OPEN_1); end
    read_disp();
    checks++; if (disp[0] !== B) begin fails++; $display("FAIL short_code_cleared: got %h want FF", disp[0]); end
  endtask

  task automatic test_unlock();
    int k0;
    logic [7:0] exp [4];
    k0 = key_cnt;
    press(1, 30); press(2, 30); press(3, 30); press(4, 30);
    checks++; if (key_cnt - k0 !== 4) begin fails++; $display("FAIL bounce_keycount: got %0d want 4", key_cnt - k0); end
    checks++; if (last_code !== 4'd4) begin fails++; $display("FAIL bounce_lastcode: got %0d want 4", last_code); end
    press(5, 0);
    read_disp();
    exp = '{SEG[4], SEG[3], SEG[2], SEG[1]};
    for (int i = 0; i < 4; i++) begin
      checks++; if (disp[i] !== exp[i]) begin fails++; $display("FAIL full_buf_digit%0d: got %h want %h", i, disp[i], exp[i]); end
    end
    press(11, 30);
    checks++; if (key_cnt - k0 !== 6) begin fails++; $display("FAIL unlock_keycount: got %0d want 6", key_cnt - k0); end
    checks++; if (last_code !== 4'd11) begin fails++; $display("FAIL unlock_hashcode: got %0d want 11", last_code); end
    checks++; if (OPEN_1 !== 1'b1 || LOCK_1 !== 1'b0) begin fails++; $display("FAIL unlock_state: got open=%b lock=%b want 1 0", OPEN_1, LOCK_1); end
    read_disp();
    checks++; if (disp[7] !== 8'hA3) begin fails++; $display("FAIL open_state_digit: got %h want A3", disp[7]); end
  endtask

  task automatic test_change_password();
    set_1 = 1'b1;
    #200;
    checks++; if (SET !== 1'b1) begin fails++; $display("FAIL set_sync: got %b want 1", SET); end
    press(11, 0);
    checks++; if (CHANGE !== 1'b1 || OPEN_1 !== 1'b0) begin fails++; $display("FAIL enter_change: got change=%b open=%b want 1 0", CHANGE, OPEN_1); end
    read_disp();
    checks++; if (disp[7] !== 8'hC6 || disp[0] !== B) begin fails++; $display("FAIL change_display: got d7=%h d0=%h want C6 FF", disp[7], disp[0]); end
    press(9, 0); press(8, 0); press(7, 0); press(11, 0);
    checks++; if (CHANGE !== 1'b1 || SAVE_LIGHT_1 !== 1'b0) begin fails++; $display("FAIL change_short_hash: got change=%b save=%b want 1 0", CHANGE, SAVE_LIGHT_1); end
    press(6, 0); press(11, 0);
    checks++; if (SAVE_LIGHT_1 !== 1'b1 || OPEN_1 !== 1'b1 || CHANGE !== 1'b0) begin fails++; $display("FAIL save_pw: got save=%b open=%b change=%b want 1 1 0", SAVE_LIGHT_1, OPEN_1, CHANGE); end
    set_1 = 1'b0;
    #200;
    press(11, 0);
    checks++; if (OPEN_1 !== 1'b1 || CHANGE !== 1'b0) begin fails++; $display("FAIL open_hash_noset: got open=%b change=%b want 1 0", OPEN_1, CHANGE); end
    press(10, 0);
    checks++; if (LOCK_1 !== 1'b1 || SAVE_LIGHT_1 !== 1'b0) begin fails++; $display("FAIL star_lock: got lock=%b save=%b want 1 0", LOCK_1, SAVE_LIGHT_1); end
    press(9, 0); press(8, 0); press(7, 0); press(6, 0); press(11, 0);
    checks++; if (OPEN_1 !== 1'b1) begin fails++; $display("FAIL new_pw_open: got %b want 1", OPEN_1); end
    press(10, 0);
    press(1, 0); press(2, 0); press(3, 0); press(4, 0); press(11, 0);
    checks++; if (LOCK_1 !== 1'b1 || OPEN_1 !== 1'b0) begin fails++; $display("FAIL old_pw_rejected: got lock=%b open=%b want 1 0", LOCK_1, OPEN_1); end
  endtask

  task automatic test_hold_glitch();
    int k0, n;
    k0 = key_cnt;
    kr = 2'd1; kc = 2'd1;
    pressed = 1'b1;
    #100000;
    pressed = 1'b0;
    #11500;
    checks++; if (key_cnt - k0 !== 1) begin fails++; $display("FAIL long_hold_count: got %0d want 1", key_cnt - k0); end
    checks++; if (last_code !== 4'd5) begin fails++; $display("FAIL long_hold_code: got %0d want 5", last_code); end
    kr = 2'd0; kc = 2'd0;
    n = 0;
    while (col !== 3'b110 && n < 60) begin @(posedge clock); n++; end
    #1;
    pressed = 1'b1;
    #800;
    pressed = 1'b0;
    #11500;
    checks++; if (key_cnt - k0 !== 1) begin fails++; $display("FAIL glitch_count: got %0d want 1", key_cnt - k0); end
    read_disp();
    checks++; if (disp[0] !== SEG[5] || disp[1] !== B) begin fails++; $display("FAIL hold_buffer: got d0=%h d1=%h want 92 FF", disp[0], disp[1]); end
    press(10, 0);
  endtask

  task automatic test_reset_in_change();
    press(9, 0); press(8, 0); press(7, 0); press(6, 0); press(11, 0);
    checks++; if (OPEN_1 !== 1'b1) begin fails++; $display("FAIL reopen: got %b want 1", OPEN_1); end
    set_1 = 1'b1;
    #200;
    press(11, 0);
    checks++; if (CHANGE !== 1'b1) begin fails++; $display("FAIL change_again: got %b want 1", CHANGE); end
    set_1 = 1'b0;
    #200;
    checks++; if (CHANGE !== 1'b0 || OPEN_1 !== 1'b1) begin fails++; $display("FAIL set_fall_abort: got change=%b open=%b want 0 1", CHANGE, OPEN_1); end
    set_1 = 1'b1;
    #200;
    press(11, 0);
    press(1, 0);
    checks++; if (CHANGE !== 1'b1) begin fails++; $display("FAIL change_before_reset: got %b want 1", CHANGE); end
    reset = 1'b0;
    #200;
    checks++; if (LOCK_1 !== 1'b1 || OPEN_1 !== 1'b0 || CHANGE !== 1'b0 || SAVE_LIGHT_1 !== 1'b0 || SET !== 1'b0) begin fails++; $display("FAIL midop_reset_leds: got lock=%b open=%b change=%b save=%b set=%b want 1 0 0 0 0", LOCK_1, OPEN_1, CHANGE, SAVE_LIGHT_1, SET); end
    checks++; if (col !== 3'b110 || wei !== 8'hFF || duan !== 8'hFF) begin fails++; $display("FAIL midop_reset_pins: got col=%b wei=%h duan=%h want 110 FF FF", col, wei, duan); end
    set_1 = 1'b0;
    reset = 1'b1;
    #11000;
    press(1, 0); press(2, 0); press(3, 0); press(4, 0); press(11, 0);
    checks++; if (OPEN_1 !== 1'b1 || LOCK_1 !== 1'b0) begin fails++; $display("FAIL default_pw_restored: got open=%b lock=%b want 1 0", OPEN_1, LOCK_1); end
  endtask

  initial begin
    test_reset();
    test_wrong_code();
    test_unlock();
    test_change_password();
    test_hold_glitch();
    test_reset_in_change();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
